// File: rtl/pll_cfg_pkg.sv
// Shared types and constants for the HDMI PLL dynamic-configuration controller.
package pll_cfg_pkg;

  localparam int unsigned DIV_W   = 10;
  localparam int unsigned PHASE_W = 13;

  localparam int unsigned PLL_DEF_IDIV  = 2;
  localparam int unsigned PLL_DEF_FDIV  = 32;
  localparam int unsigned PLL_DEF_ODIV  = 100;
  localparam int unsigned PLL_DEF_DUTY  = 100;
  localparam int unsigned PLL_DEF_PHASE = 16;

  typedef enum logic [1:0] {
    StRst,
    StWait,
    StRun,
    StFail
  } pll_state_e;

  typedef struct packed {
    logic [DIV_W-1:0]   idiv;
    logic [DIV_W-1:0]   fdiv;
    logic [DIV_W-1:0]   odiv0;
    logic [DIV_W-1:0]   odiv1;
    logic [DIV_W-1:0]   duty0;
    logic [DIV_W-1:0]   duty1;
    logic [PHASE_W-1:0] phase0;
    logic [PHASE_W-1:0] phase1;
  } pll_cfg_t;

  // Bits needed to hold values 0..value-1; never less than one.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 1;
    while ((32'd1 << width) < value) begin
      width++;
    end
    return width;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL lock into the clk domain.
module pll_lock_sync (
  input  logic clk,
  input  logic rst,
  input  logic lock_i,
  output logic lock_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= lock_i;
      sync_q <= meta_q;
    end
  end

  assign lock_o = sync_q;

endmodule

// File: rtl/pll_dyn_cfg_ctrl.sv
// HDMI PLL dynamic-configuration controller: applies divider sets, sequences PLL reset
// and lock acquisition, and reports done/error/lock-loss status.
module pll_dyn_cfg_ctrl
  import pll_cfg_pkg::*;
#(
  parameter int unsigned RST_HOLD     = 16,
  parameter int unsigned LOCK_STABLE  = 8,
  parameter int unsigned LOCK_TIMEOUT = 200000,
  parameter int unsigned DEF_IDIV     = PLL_DEF_IDIV,
  parameter int unsigned DEF_FDIV     = PLL_DEF_FDIV,
  parameter int unsigned DEF_ODIV     = PLL_DEF_ODIV,
  parameter int unsigned DEF_DUTY     = PLL_DEF_DUTY,
  parameter int unsigned DEF_PHASE    = PLL_DEF_PHASE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [DIV_W-1:0]   cfg_idiv,
  input  logic [DIV_W-1:0]   cfg_fdiv,
  input  logic [DIV_W-1:0]   cfg_odiv0,
  input  logic [DIV_W-1:0]   cfg_odiv1,
  input  logic [DIV_W-1:0]   cfg_duty0,
  input  logic [DIV_W-1:0]   cfg_duty1,
  input  logic [PHASE_W-1:0] cfg_phase0,
  input  logic [PHASE_W-1:0] cfg_phase1,
  input  logic               pll_lock,
  output logic               pll_rst,
  output logic [DIV_W-1:0]   dyn_idiv,
  output logic [DIV_W-1:0]   dyn_fdiv,
  output logic [DIV_W-1:0]   dyn_odiv0,
  output logic [DIV_W-1:0]   dyn_odiv1,
  output logic [DIV_W-1:0]   dyn_duty0,
  output logic [DIV_W-1:0]   dyn_duty1,
  output logic [PHASE_W-1:0] dyn_phase0,
  output logic [PHASE_W-1:0] dyn_phase1,
  output logic               locked,
  output logic               busy,
  output logic               cfg_done,
  output logic               cfg_err,
  output logic [7:0]         lock_loss_cnt
);

  localparam int unsigned RstW  = clog2(RST_HOLD);
  localparam int unsigned StabW = clog2(LOCK_STABLE + 1);
  localparam int unsigned TimeW = clog2(LOCK_TIMEOUT + 1);

  localparam pll_cfg_t DefCfg = '{
    idiv:   DIV_W'(DEF_IDIV),
    fdiv:   DIV_W'(DEF_FDIV),
    odiv0:  DIV_W'(DEF_ODIV),
    odiv1:  DIV_W'(DEF_ODIV),
    duty0:  DIV_W'(DEF_DUTY),
    duty1:  DIV_W'(DEF_DUTY),
    phase0: PHASE_W'(DEF_PHASE),
    phase1: PHASE_W'(DEF_PHASE)
  };

  pll_state_e       state_q, state_d;
  logic [RstW-1:0]  rst_cnt_q, rst_cnt_d;
  logic [TimeW-1:0] timeout_q, timeout_d;
  logic [StabW-1:0] stable_q, stable_d;
  logic             pll_rst_q;
  logic             cfg_done_q, cfg_done_d;
  logic             cfg_err_q, cfg_err_d;
  logic [7:0]       lock_loss_q;
  pll_cfg_t         dyn_q, cfg_req;
  logic             lock_s, xfer, cfg_ok, load_cfg, loss_inc;

  pll_lock_sync u_lock_sync (
    .clk    (clk),
    .rst    (rst),
    .lock_i (pll_lock),
    .lock_o (lock_s)
  );

  assign cfg_req = '{
    idiv:   cfg_idiv,
    fdiv:   cfg_fdiv,
    odiv0:  cfg_odiv0,
    odiv1:  cfg_odiv1,
    duty0:  cfg_duty0,
    duty1:  cfg_duty1,
    phase0: cfg_phase0,
    phase1: cfg_phase1
  };

  assign cfg_ok = (|cfg_idiv) && (|cfg_fdiv) && (|cfg_odiv0) && (|cfg_odiv1);
  assign xfer   = cfg_valid && cfg_ready;

  // Consecutive synchronized-lock count, saturating once the stability target is met.
  always_comb begin
    stable_d = '0;
    if (lock_s) begin
      stable_d = (stable_q == StabW'(LOCK_STABLE)) ? stable_q : stable_q + 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = '0;
    timeout_d  = '0;
    cfg_done_d = 1'b0;
    cfg_err_d  = 1'b0;
    load_cfg   = 1'b0;
    loss_inc   = 1'b0;
    unique case (state_q)
      StRst: begin
        rst_cnt_d = rst_cnt_q + 1'b1;
        if (rst_cnt_q == RstW'(RST_HOLD - 1)) begin
          rst_cnt_d = '0;
          state_d   = StWait;
        end
      end
      StWait: begin
        timeout_d = timeout_q + 1'b1;
        // Lock takes priority over a simultaneous timeout.
        if (stable_d == StabW'(LOCK_STABLE)) begin
          state_d    = StRun;
          cfg_done_d = 1'b1;
        end else if (timeout_d == TimeW'(LOCK_TIMEOUT)) begin
          state_d   = StFail;
          cfg_err_d = 1'b1;
        end
      end
      StRun: begin
        if (!lock_s) begin
          loss_inc = 1'b1;
          state_d  = StWait;
        end
      end
      StFail: ;
      default: state_d = StRst;
    endcase
    // An accepted request overrides the lock-loss transition but not its count.
    if (xfer) begin
      if (cfg_ok) begin
        load_cfg = 1'b1;
        state_d  = StRst;
      end else begin
        cfg_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StRst;
      rst_cnt_q   <= '0;
      timeout_q   <= '0;
      stable_q    <= '0;
      pll_rst_q   <= 1'b1;
      cfg_done_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
      dyn_q       <= DefCfg;
      lock_loss_q <= '0;
    end else begin
      state_q    <= state_d;
      rst_cnt_q  <= rst_cnt_d;
      timeout_q  <= timeout_d;
      stable_q   <= stable_d;
      pll_rst_q  <= (state_d == StRst);
      cfg_done_q <= cfg_done_d;
      cfg_err_q  <= cfg_err_d;
      if (load_cfg) begin
        dyn_q <= cfg_req;
      end
      if (loss_inc && (lock_loss_q != 8'hff)) begin
        lock_loss_q <= lock_loss_q + 8'd1;
      end
    end
  end

  assign cfg_ready     = (state_q == StRun) || (state_q == StFail);
  assign locked        = (state_q == StRun);
  assign busy          = (state_q == StRst) || (state_q == StWait);
  assign pll_rst       = pll_rst_q;
  assign cfg_done      = cfg_done_q;
  assign cfg_err       = cfg_err_q;
  assign lock_loss_cnt = lock_loss_q;

  assign dyn_idiv   = dyn_q.idiv;
  assign dyn_fdiv   = dyn_q.fdiv;
  assign dyn_odiv0  = dyn_q.odiv0;
  assign dyn_odiv1  = dyn_q.odiv1;
  assign dyn_duty0  = dyn_q.duty0;
  assign dyn_duty1  = dyn_q.duty1;
  assign dyn_phase0 = dyn_q.phase0;
  assign dyn_phase1 = dyn_q.phase1;

endmodule

// File: tb/tb_pll_dyn_cfg_ctrl.sv
// Scoreboard bench for pll_dyn_cfg_ctrl: a reference model predicts every output cycle,
// a monitor compares after each rising edge.
module tb_pll_dyn_cfg_ctrl;

  localparam int RH = 4;
  localparam int LS = 3;
  localparam int LT = 100;
  localparam logic [85:0] DEF_DYN =
    {10'd2, 10'd32, 10'd100, 10'd100, 10'd100, 10'd100, 13'd16, 13'd16};
  localparam int M_HOLD = 0;
  localparam int M_WAIT = 1;
  localparam int M_RUN  = 2;
  localparam int M_FAIL = 3;

  logic clk_tb = 1'b0;
  always #5 clk_tb = ~clk_tb;

  logic        rst, cfg_valid, pll_lock;
  logic [9:0]  cfg_idiv, cfg_fdiv, cfg_odiv0, cfg_odiv1, cfg_duty0, cfg_duty1;
  logic [12:0] cfg_phase0, cfg_phase1;
  logic        cfg_ready, pll_rst, locked, busy, cfg_done, cfg_err;
  logic [9:0]  dyn_idiv, dyn_fdiv, dyn_odiv0, dyn_odiv1, dyn_duty0, dyn_duty1;
  logic [12:0] dyn_phase0, dyn_phase1;
  logic [7:0]  lock_loss_cnt;
  logic [85:0] dyn_all;
  logic [5:0]  status;

  assign dyn_all = {dyn_idiv, dyn_fdiv, dyn_odiv0, dyn_odiv1, dyn_duty0, dyn_duty1,
                    dyn_phase0, dyn_phase1};
  assign status  = {pll_rst, cfg_ready, locked, busy, cfg_done, cfg_err};

  pll_dyn_cfg_ctrl #(
    .RST_HOLD     (RH),
    .LOCK_STABLE  (LS),
    .LOCK_TIMEOUT (LT)
  ) dut (
    .clk           (clk_tb),
    .rst           (rst),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_idiv      (cfg_idiv),
    .cfg_fdiv      (cfg_fdiv),
    .cfg_odiv0     (cfg_odiv0),
    .cfg_odiv1     (cfg_odiv1),
    .cfg_duty0     (cfg_duty0),
    .cfg_duty1     (cfg_duty1),
    .cfg_phase0    (cfg_phase0),
    .cfg_phase1    (cfg_phase1),
    .pll_lock      (pll_lock),
    .pll_rst       (pll_rst),
    .dyn_idiv      (dyn_idiv),
    .dyn_fdiv      (dyn_fdiv),
    .dyn_odiv0     (dyn_odiv0),
    .dyn_odiv1     (dyn_odiv1),
    .dyn_duty0     (dyn_duty0),
    .dyn_duty1     (dyn_duty1),
    .dyn_phase0    (dyn_phase0),
    .dyn_phase1    (dyn_phase1),
    .locked        (locked),
    .busy          (busy),
    .cfg_done      (cfg_done),
    .cfg_err       (cfg_err),
    .lock_loss_cnt (lock_loss_cnt)
  );

  typedef struct packed {
    logic [5:0]  status;
    logic [7:0]  loss;
    logic [85:0] dyn;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;

  // Reference model: operating mode plus elapsed-cycle counts and the raw lock history.
  int          m_mode, m_hold, m_wait, m_loss;
  bit          m_done, m_err;
  logic [85:0] m_dyn;
  bit          m_hist[$];

  logic [9:0]  s_idiv, s_fdiv, s_odiv0, s_odiv1, s_duty0, s_duty1;
  logic [12:0] s_phase0, s_phase1;

  function automatic void check(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_mode = M_HOLD;
    m_hold = 0;
    m_wait = 0;
    m_loss = 0;
    m_done = 1'b0;
    m_err  = 1'b0;
    m_dyn  = DEF_DYN;
    m_hist.delete();
  endfunction

  // Synchronized lock as seen 'back' cycles behind the latest raw sample.
  function automatic bit synced_lock(input int back);
    int idx;
    idx = m_hist.size() - 1 - back;
    return (idx >= 0) ? m_hist[idx] : 1'b0;
  endfunction

  function automatic void model_step();
    bit rdy, ok, lock_now, stable_ok;
    int nxt;
    rdy      = (m_mode == M_RUN) || (m_mode == M_FAIL);
    ok       = (cfg_idiv != 0) && (cfg_fdiv != 0) && (cfg_odiv0 != 0) && (cfg_odiv1 != 0);
    lock_now = synced_lock(1);
    stable_ok = 1'b1;
    for (int i = 1; i <= LS; i++) begin
      if (!synced_lock(i)) stable_ok = 1'b0;
    end
    m_done = 1'b0;
    m_err  = 1'b0;
    nxt    = m_mode;
    case (m_mode)
      M_HOLD: begin
        m_hold++;
        if (m_hold == RH) nxt = M_WAIT;
      end
      M_WAIT: begin
        m_wait++;
        if (stable_ok) begin
          nxt = M_RUN;
          m_done = 1'b1;
        end else if (m_wait == LT) begin
          nxt = M_FAIL;
          m_err = 1'b1;
        end
      end
      M_RUN: begin
        if (!lock_now) begin
          if (m_loss < 255) m_loss++;
          nxt = M_WAIT;
        end
      end
      default: ;
    endcase
    if (cfg_valid && rdy) begin
      if (ok) begin
        m_dyn = {cfg_idiv, cfg_fdiv, cfg_odiv0, cfg_odiv1, cfg_duty0, cfg_duty1,
                 cfg_phase0, cfg_phase1};
        nxt = M_HOLD;
      end else begin
        m_err = 1'b1;
      end
    end
    if (nxt == M_HOLD && m_mode != M_HOLD) m_hold = 0;
    if (nxt == M_WAIT && m_mode != M_WAIT) m_wait = 0;
    m_mode = nxt;
    m_hist.push_back(pll_lock);
    if (m_hist.size() > 8) void'(m_hist.pop_front());
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.status = {m_mode == M_HOLD, (m_mode == M_RUN) || (m_mode == M_FAIL), m_mode == M_RUN,
                (m_mode == M_HOLD) || (m_mode == M_WAIT), m_done, m_err};
    e.loss   = 8'(m_loss);
    e.dyn    = m_dyn;
    return e;
  endfunction

  function automatic void rand_fields(input bit allow_bad);
    s_idiv   = 10'($urandom_range(1, 1023));
    s_fdiv   = 10'($urandom_range(1, 1023));
    s_odiv0  = 10'($urandom_range(1, 1023));
    s_odiv1  = 10'($urandom_range(1, 1023));
    s_duty0  = 10'($urandom_range(0, 1023));
    s_duty1  = 10'($urandom_range(0, 1023));
    s_phase0 = 13'($urandom_range(0, 8191));
    s_phase1 = 13'($urandom_range(0, 8191));
    if (allow_bad && $urandom_range(0, 3) == 0) begin
      case ($urandom_range(0, 3))
        0: s_idiv = '0;
        1: s_fdiv = '0;
        2: s_odiv0 = '0;
        default: s_odiv1 = '0;
      endcase
    end
  endfunction

  task automatic step(input bit valid, input bit lk);
    @(negedge clk_tb);
    cfg_valid  = valid;
    cfg_idiv   = s_idiv;
    cfg_fdiv   = s_fdiv;
    cfg_odiv0  = s_odiv0;
    cfg_odiv1  = s_odiv1;
    cfg_duty0  = s_duty0;
    cfg_duty1  = s_duty1;
    cfg_phase0 = s_phase0;
    cfg_phase1 = s_phase1;
    pll_lock   = lk;
    if (!rst) model_step();
    exp_q.push_back(model_out());
  endtask

  task automatic idle(input int n, input bit lk);
    repeat (n) begin
      rand_fields(1'b1);
      step(1'b0, lk);
    end
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk_tb);
    rst       = 1'b1;
    cfg_valid = 1'b0;
    pll_lock  = 1'b0;
    model_reset();
    #1;
    check("async_rst_status", 128'(status), 128'(6'b100100));
    check("async_rst_loss", 128'(lock_loss_cnt), 128'(0));
    check("async_rst_dyn", 128'(dyn_all), 128'(DEF_DYN));
    exp_q.push_back(model_out());
    repeat (hold - 1) begin
      @(negedge clk_tb);
      exp_q.push_back(model_out());
    end
    @(negedge clk_tb);
    rst = 1'b0;
    model_step();
    exp_q.push_back(model_out());
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk_tb);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("status{rst,rdy,lck,busy,done,err}", 128'(status), 128'(e.status));
        check("lock_loss_cnt", 128'(lock_loss_cnt), 128'(e.loss));
        check("dyn", 128'(dyn_all), 128'(e.dyn));
        if (cfg_done === 1'b1) done_cnt++;
      end
    end
  end

  initial begin : stimulus
    bit lk;
    int run;
    rst        = 1'b0;
    cfg_valid  = 1'b0;
    pll_lock   = 1'b0;
    cfg_idiv   = '0;
    cfg_fdiv   = '0;
    cfg_odiv0  = '0;
    cfg_odiv1  = '0;
    cfg_duty0  = '0;
    cfg_duty1  = '0;
    cfg_phase0 = '0;
    cfg_phase1 = '0;
    rand_fields(1'b0);
    model_reset();

    // Power-up: lock arrives 10 cycles after pll_rst falls.
    do_reset(3);
    idle(RH - 1 + 10, 1'b0);
    idle(10, 1'b1);
    check("done_pulses_powerup", 128'(done_cnt), 128'(1));

    // Reconfigure in RUN; PLL drops lock while held in reset, then relocks.
    s_idiv = 10'd2; s_fdiv = 10'd32; s_odiv0 = 10'd200; s_odiv1 = 10'd200;
    s_duty0 = 10'd200; s_duty1 = 10'd200; s_phase0 = 13'd16; s_phase1 = 13'd16;
    step(1'b1, 1'b1);
    idle(8, 1'b0);
    idle(12, 1'b1);
    check("done_pulses_reconfig", 128'(done_cnt), 128'(2));

    // Lock never arrives: timeout to FAIL, then a valid request restarts.
    rand_fields(1'b0);
    step(1'b1, 1'b0);
    idle(RH + LT + 10, 1'b0);
    rand_fields(1'b0);
    step(1'b1, 1'b0);
    idle(RH + 2, 1'b0);
    idle(10, 1'b1);

    // Rejected request in RUN.
    rand_fields(1'b0);
    s_fdiv = '0;
    step(1'b1, 1'b1);
    idle(3, 1'b1);

    // Repeated lock glitches drive the loss counter into saturation.
    for (int g = 0; g < 300; g++) begin
      idle($urandom_range(1, 5), 1'b0);
      idle($urandom_range(6, 10), 1'b1);
    end
    check("loss_saturated", 128'(lock_loss_cnt), 128'(255));

    // Reset asserted while waiting for lock.
    idle(2, 1'b0);
    do_reset(3);
    idle(RH + 3, 1'b0);
    idle(10, 1'b1);

    // Randomized traffic with lock bursts and occasional resets.
    lk  = 1'b1;
    run = 10;
    for (int c = 0; c < 3000; c++) begin
      if (run == 0) begin
        lk  = ~lk;
        run = ($urandom_range(0, 9) == 0) ? 150 : $urandom_range(1, 30);
      end
      run--;
      if ($urandom_range(0, 399) == 0) begin
        do_reset(2);
      end else begin
        rand_fields(1'b1);
        step($urandom_range(0, 5) == 0, lk);
      end
    end

    @(posedge clk_tb);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
